booth_mul_iter: RTL and testbench



---
 rtl/booth_mul_iter_pkg.sv | 31 +++
 rtl/booth_r4_sel.sv | 30 +++
 rtl/booth_mul_iter.sv | 143 ++++++++++++++
 tb/tb_booth_mul_iter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mul_iter_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: FSM states and digit codes.
package booth_mul_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_POS1 = 3'd1,
        BOOTH_POS2 = 3'd2,
        BOOTH_NEG2 = 3'd3,
        BOOTH_NEG1 = 3'd4
    } booth_op_t;

    // Decode a {y[2i+1], y[2i], y[2i-1]} window into a partial-product operation.
    function automatic booth_op_t booth_decode(input logic [2:0] digit);
        booth_op_t op;
        case (digit)
            3'b001, 3'b010: op = BOOTH_POS1;
            3'b011:         op = BOOTH_POS2;
            3'b100:         op = BOOTH_NEG2;
            3'b101, 3'b110: op = BOOTH_NEG1;
            default:        op = BOOTH_ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector: picks 0, +/-X or +/-2X of a pre-shifted multiplicand.
module booth_r4_sel
    import booth_mul_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]         digit,
    input  logic [2*WIDTH-1:0] mcand,
    output logic [2*WIDTH-1:0] pp_c
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0] mcand_x2;

    assign mcand_x2 = {mcand[PW-2:0], 1'b0};

    // Select the partial product; negation is modulo 2^PW.
    always_comb begin
        pp_c = '0;
        case (booth_decode(digit))
            BOOTH_POS1: pp_c = mcand;
            BOOTH_POS2: pp_c = mcand_x2;
            BOOTH_NEG2: pp_c = PW'(0) - mcand_x2;
            BOOTH_NEG1: pp_c = PW'(0) - mcand;
            default:    pp_c = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier retiring DIGITS_PER_CYCLE digits per cycle,
// valid/ready on both sides, synchronous flush.
module booth_mul_iter
    import booth_mul_iter_pkg::*;
#(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned DIGITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mul_signed,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned K     = DIGITS_PER_CYCLE;
    localparam int unsigned N     = (WIDTH + 2) / 2;
    localparam int unsigned C     = (N + K - 1) / K;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned YW    = 2 * K * C;
    localparam int unsigned ML    = YW + 1;
    localparam int unsigned CNT_W = (C + 1 > 1) ? $clog2(C + 1) : 1;

    state_t             state_q, state_d;
    logic               in_ready_d, out_valid_d;
    logic [PW-1:0]      result_d;
    logic [PW-1:0]      acc_q, acc_d, acc_sum;
    logic [PW-1:0]      mcand_q, mcand_d;
    // Bit 0 holds y[-1]; digit j of the current cycle sits at [2j+2:2j].
    logic [ML-1:0]      mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      mcand_ext;
    logic [ML-1:0]      mplier_ext;
    logic [PW-1:0]      pp [K];

    assign mcand_ext  = {{WIDTH{mul_signed & src1[WIDTH-1]}}, src1};
    assign mplier_ext = {{(YW - WIDTH){mul_signed & src2[WIDTH-1]}}, src2, 1'b0};

    // One selector per digit retired this cycle, each seeing the multiplicand at its digit weight.
    for (genvar j = 0; j < K; j++) begin : g_sel
        booth_r4_sel #(
            .WIDTH (WIDTH)
        ) u_sel (
            .digit (mplier_q[2*j+2 -: 3]),
            .mcand (mcand_q << (2 * j)),
            .pp_c  (pp[j])
        );
    end

    // Accumulator plus this cycle's partial products.
    always_comb begin
        acc_sum = acc_q;
        for (int j = 0; j < K; j++) begin
            acc_sum = acc_sum + pp[j];
        end
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        result_d    = result;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;

        if (flush) begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_d    = ST_CALC;
                        in_ready_d = 1'b0;
                        mcand_d    = mcand_ext;
                        mplier_d   = mplier_ext;
                        acc_d      = '0;
                        cnt_d      = '0;
                    end
                end
                ST_CALC: begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << (2 * K);
                    mplier_d = ML'($signed(mplier_q) >>> (2 * K));
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(C - 1)) begin
                        state_d     = ST_DONE;
                        result_d    = acc_sum;
                        out_valid_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            result    <= result_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_booth_mul_iter.sv
// Bench for booth_mul_iter: three configurations (32/K1, 32/K4, 8/K2) with directed vectors.
module tb_booth_mul_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        flush;
    logic [2:0]  in_valid;
    logic [2:0]  mul_signed;
    logic [2:0]  out_ready;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [31:0] src1 [3];
    logic [31:0] src2 [3];
    logic [63:0] res0, res1;
    logic [15:0] res8;

    int checks = 0;
    int errors = 0;

    booth_mul_iter #(.WIDTH(32), .DIGITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .mul_signed(mul_signed[0]),
        .src1(src1[0]), .src2(src2[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(res0)
    );

    booth_mul_iter #(.WIDTH(32), .DIGITS_PER_CYCLE(4)) u_dut_k4 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .mul_signed(mul_signed[1]),
        .src1(src1[1]), .src2(src2[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(res1)
    );

    booth_mul_iter #(.WIDTH(8), .DIGITS_PER_CYCLE(2)) u_dut_w8 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .mul_signed(mul_signed[2]),
        .src1(src1[2][7:0]), .src2(src2[2][7:0]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .result(res8)
    );

    typedef struct {
        int          dut;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vt [15];

    function automatic logic [63:0] get_res(input int i);
        if (i == 0) return res0;
        if (i == 1) return res1;
        return {48'b0, res8};
    endfunction

    // 32/K1: N=17 -> 17; 32/K4: ceil(17/4)=5; 8/K2: N=5, ceil(5/2)=3.
    function automatic int lat_of(input int i);
        if (i == 0) return 17;
        if (i == 1) return 5;
        return 3;
    endfunction

    function automatic logic [63:0] ref_mul(input int i, input logic s,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        if (i == 2) begin
            ea = s ? {{56{a[7]}}, a[7:0]} : {56'b0, a[7:0]};
            eb = s ? {{56{b[7]}}, b[7:0]} : {56'b0, b[7:0]};
            p  = ea * eb;
            return {48'b0, p[15:0]};
        end
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge, then scramble inputs so later changes must be ignored.
    task automatic start_op(input int i, input logic s, input logic [31:0] a, input logic [31:0] b);
        mul_signed[i] = s;
        src1[i]       = a;
        src2[i]       = b;
        in_valid[i]   = 1'b1;
        step();
        in_valid[i]   = 1'b0;
        src1[i]       = $urandom;
        src2[i]       = $urandom;
        mul_signed[i] = ~s;
    endtask

    task automatic wait_valid(input int i, output int lat);
        logic ready_seen;
        ready_seen = 1'b0;
        lat = 0;
        while (!out_valid[i] && lat < 40) begin
            if (in_ready[i]) ready_seen = 1'b1;
            in_valid[i] = lat[0];
            step();
            lat++;
        end
        in_valid[i] = 1'b0;
        chk("ready_low_busy", {63'b0, ready_seen | in_ready[i]}, 64'd0);
    endtask

    task automatic run(input int i, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string name);
        int lat;
        chk({name, "_accept_ready"}, {63'b0, in_ready[i]}, 64'd1);
        start_op(i, s, a, b);
        wait_valid(i, lat);
        chk({name, "_latency"}, 64'(lat), 64'(lat_of(i)));
        chk({name, "_result"}, get_res(i), exp);
        out_ready[i] = 1'b1;
        step();
        out_ready[i] = 1'b0;
        chk({name, "_handoff"}, {62'b0, out_valid[i], in_ready[i]}, 64'd1);
    endtask

    initial begin
        int lat;
        int seen;
        logic s;
        logic [31:0] a, b;

        resetn     = 1'b0;
        flush      = 1'b0;
        in_valid   = '0;
        mul_signed = '0;
        out_ready  = '0;
        for (int i = 0; i < 3; i++) begin
            src1[i] = '0;
            src2[i] = '0;
        end

        vt[0]  = '{0, 1'b1, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB};
        vt[1]  = '{0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vt[2]  = '{0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
        vt[3]  = '{0, 1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000};
        vt[4]  = '{0, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
        vt[5]  = '{0, 1'b0, 32'h00000003, 32'h00000005, 64'h000000000000000F};
        vt[6]  = '{0, 1'b1, 32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000};
        vt[7]  = '{0, 1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};
        vt[8]  = '{1, 1'b0, 32'h12345678, 32'h00000010, 64'h0000000123456780};
        vt[9]  = '{1, 1'b1, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFFFFFFFFFE};
        vt[10] = '{1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vt[11] = '{2, 1'b1, 32'h00000080, 32'h00000080, 64'h0000000000004000};
        vt[12] = '{2, 1'b0, 32'h000000FF, 32'h000000FF, 64'h000000000000FE01};
        vt[13] = '{2, 1'b1, 32'h000000FF, 32'h00000003, 64'h000000000000FFFD};
        vt[14] = '{2, 1'b1, 32'h0000007F, 32'h00000080, 64'h000000000000C080};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_out_valid", {63'b0, out_valid[i]}, 64'd0);
            chk("reset_in_ready", {63'b0, in_ready[i]}, 64'd1);
            chk("reset_result", get_res(i), 64'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        step();

        for (int k = 0; k < 15; k++) begin
            run(vt[k].dut, vt[k].sgn, vt[k].a, vt[k].b, vt[k].exp, $sformatf("vec%0d", k));
        end

        // Backpressure: result and out_valid hold while out_ready is low.
        start_op(0, 1'b1, 32'd6, 32'd7);
        wait_valid(0, lat);
        chk("bp_latency", 64'(lat), 64'd17);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_valid_hold", {63'b0, out_valid[0]}, 64'd1);
            chk("bp_result_hold", res0, 64'd42);
            chk("bp_ready_low", {63'b0, in_ready[0]}, 64'd0);
        end
        out_ready[0] = 1'b1;
        step();
        out_ready[0] = 1'b0;
        chk("bp_release", {62'b0, out_valid[0], in_ready[0]}, 64'd1);

        // Flush during the fifth CALC cycle: no result, old result kept.
        start_op(0, 1'b1, 32'd100, 32'd200);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_calc_state", {62'b0, out_valid[0], in_ready[0]}, 64'd1);
        chk("flush_calc_result", res0, 64'd42);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (out_valid[0]) seen++;
        end
        chk("flush_calc_no_valid", 64'(seen), 64'd0);
        run(0, 1'b1, 32'd3, 32'd5, 64'd15, "post_flush");

        // Flush in IDLE with in_valid: nothing accepted.
        mul_signed[0] = 1'b0;
        src1[0]       = 32'd9;
        src2[0]       = 32'd9;
        in_valid[0]   = 1'b1;
        flush         = 1'b1;
        step();
        flush         = 1'b0;
        in_valid[0]   = 1'b0;
        chk("flush_idle_ready", {63'b0, in_ready[0]}, 64'd1);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (out_valid[0] || !in_ready[0]) seen++;
        end
        chk("flush_idle_no_accept", 64'(seen), 64'd0);

        // Flush in DONE drops out_valid but keeps the loaded result.
        start_op(0, 1'b1, 32'd9, 32'd9);
        wait_valid(0, lat);
        chk("flush_done_result_pre", res0, 64'd81);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_done_state", {62'b0, out_valid[0], in_ready[0]}, 64'd1);
        chk("flush_done_result", res0, 64'd81);

        // Flush together with out_ready behaves as flush.
        start_op(0, 1'b0, 32'd10, 32'd10);
        wait_valid(0, lat);
        flush        = 1'b1;
        out_ready[0] = 1'b1;
        step();
        flush        = 1'b0;
        out_ready[0] = 1'b0;
        chk("flush_ordy_state", {62'b0, out_valid[0], in_ready[0]}, 64'd1);
        chk("flush_ordy_result", res0, 64'd100);

        // Asynchronous reset mid-CALC.
        start_op(0, 1'b1, 32'd12345, 32'd678);
        repeat (3) step();
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_mid_valid", {63'b0, out_valid[0]}, 64'd0);
        chk("rst_mid_ready", {63'b0, in_ready[0]}, 64'd1);
        chk("rst_mid_result", res0, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        step();
        run(0, 1'b0, 32'd3, 32'd5, 64'd15, "post_reset");

        // Random operands against a reference product.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 60; n++) begin
                a = $urandom;
                b = $urandom;
                s = 1'($urandom_range(0, 1));
                run(i, s, a, b, ref_mul(i, s, a, b), $sformatf("rand_d%0d", i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
